// File: rtl/sgdmac_distributor.sv
// Return-path splitter: steers each source packet to the rm or dt channel
// using the select sampled on its first beat. Each channel has a 2-entry output FIFO.
module sgdmac_distributor #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [DATA_SIZE-1:0] src_data_i,
  input  logic                 src_sel_i,
  input  logic                 src_last_i,
  output logic                 rm_valid_o,
  input  logic                 rm_ready_i,
  output logic [DATA_SIZE-1:0] rm_data_o,
  output logic                 rm_last_o,
  output logic                 dt_valid_o,
  input  logic                 dt_ready_i,
  output logic [DATA_SIZE-1:0] dt_data_o,
  output logic                 dt_last_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, ROUTE_RM, ROUTE_DT} state_t;

  state_t               state_q, state_d;
  logic                 run_q;
  // Channel index: 1 = rm, 0 = dt.
  logic [1:0][1:0]      cnt_q, cnt_d;
  logic [1:0]           wr_q, rd_q;
  logic [DATA_SIZE:0]   mem_q [2][2];
  logic                 target;
  logic                 accept;
  logic [1:0]           push, pop, valid;

  always_comb begin
    case (state_q)
      ROUTE_RM: target = 1'b1;
      ROUTE_DT: target = 1'b0;
      default:  target = src_sel_i;
    endcase
  end

  // run_q holds ready low while in reset; ready never looks at sink ready.
  assign src_ready_o = run_q & (cnt_q[target] < 2'd2);
  assign accept      = src_valid_i & src_ready_o;
  assign push        = accept ? (target ? 2'b10 : 2'b01) : 2'b00;
  assign valid       = {cnt_q[1] != 2'd0, cnt_q[0] != 2'd0};
  assign pop         = valid & {rm_ready_i, dt_ready_i};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cnt_d[c] = cnt_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:    if (!src_last_i) state_d = src_sel_i ? ROUTE_RM : ROUTE_DT;
        default: if (src_last_i) state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int c = 0; c < 2; c++) begin
        mem_q[c][0] <= '0;
        mem_q[c][1] <= '0;
      end
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      cnt_q   <= cnt_d;
      for (int c = 0; c < 2; c++) begin
        if (push[c]) mem_q[c][wr_q[c]] <= {src_last_i, src_data_i};
        wr_q[c] <= wr_q[c] ^ push[c];
        rd_q[c] <= rd_q[c] ^ pop[c];
      end
    end
  end

  assign rm_valid_o = valid[1];
  assign dt_valid_o = valid[0];
  assign {rm_last_o, rm_data_o} = valid[1] ? mem_q[1][rd_q[1]] : '0;
  assign {dt_last_o, dt_data_o} = valid[0] ? mem_q[0][rd_q[0]] : '0;
  assign busy_o = (state_q != IDLE) | (valid != 2'b00);

endmodule

// File: tb/tb_sgdmac_distributor.sv
// Directed plus randomized bench for sgdmac_distributor against a queue-based
// packet-routing model.
module tb_sgdmac_distributor;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          src_valid_i, src_sel_i, src_last_i;
  logic [DW-1:0] src_data_i;
  logic          src_ready_o;
  logic          rm_valid_o, rm_ready_i, rm_last_o;
  logic [DW-1:0] rm_data_o;
  logic          dt_valid_o, dt_ready_i, dt_last_o;
  logic [DW-1:0] dt_data_o;
  logic          busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one queue of {last,data} per channel plus packet lock.
  logic [DW:0] rmq[$];
  logic [DW:0] dtq[$];
  bit          in_pkt;
  bit          pkt_tgt;
  bit          rdy_exp;

  sgdmac_distributor #(.DATA_SIZE(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_data_i(src_data_i), .src_sel_i(src_sel_i), .src_last_i(src_last_i),
    .rm_valid_o(rm_valid_o), .rm_ready_i(rm_ready_i),
    .rm_data_o(rm_data_o), .rm_last_o(rm_last_o),
    .dt_valid_o(dt_valid_o), .dt_ready_i(dt_ready_i),
    .dt_data_o(dt_data_o), .dt_last_o(dt_last_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit tgt;
    tgt     = in_pkt ? pkt_tgt : src_sel_i;
    rdy_exp = (tgt ? rmq.size() : dtq.size()) < 2;
    check("src_ready", src_ready_o, rdy_exp);
    check("rm_valid", rm_valid_o, rmq.size() != 0);
    check("dt_valid", dt_valid_o, dtq.size() != 0);
    check("busy", busy_o, in_pkt || rmq.size() != 0 || dtq.size() != 0);
    if (rmq.size() != 0) begin
      check("rm_data", rm_data_o, rmq[0][DW-1:0]);
      check("rm_last", rm_last_o, rmq[0][DW]);
    end
    if (dtq.size() != 0) begin
      check("dt_data", dt_data_o, dtq[0][DW-1:0]);
      check("dt_last", dt_last_o, dtq[0][DW]);
    end
  endtask

  // Called at posedge+1: drive, check before the edge, then advance the model.
  task automatic cycle(input bit v, input bit s, input bit l, input logic [DW-1:0] d,
                       input bit rr, input bit dr);
    bit acc, tgt;
    src_valid_i = v; src_sel_i = s; src_last_i = l; src_data_i = d;
    rm_ready_i = rr; dt_ready_i = dr;
    #1;
    check_outputs();
    tgt = in_pkt ? pkt_tgt : s;
    acc = v && rdy_exp;
    @(posedge clk);
    if (rmq.size() != 0 && rr) void'(rmq.pop_front());
    if (dtq.size() != 0 && dr) void'(dtq.pop_front());
    if (acc) begin
      if (tgt) rmq.push_back({l, d}); else dtq.push_back({l, d});
      if (!in_pkt && !l) begin in_pkt = 1; pkt_tgt = s; end
      else if (in_pkt && l) in_pkt = 0;
    end
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_src_ready", src_ready_o, 1'b0);
    check("rst_rm_valid", rm_valid_o, 1'b0);
    check("rst_rm_data", rm_data_o, '0);
    check("rst_rm_last", rm_last_o, 1'b0);
    check("rst_dt_valid", dt_valid_o, 1'b0);
    check("rst_dt_data", dt_data_o, '0);
    check("rst_dt_last", dt_last_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    src_valid_i = 0; src_sel_i = 0; src_last_i = 0; src_data_i = '0;
    rm_ready_i = 0; dt_ready_i = 0;
    in_pkt = 0; pkt_tgt = 0;
    #3;
    check_reset_outputs();
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset release: everything idle, ready high.
    cycle(0, 0, 0, 32'h0, 0, 0);

    // Single-beat rm packet.
    cycle(1, 1, 1, 32'hA5A5_0001, 1, 0);
    check("single_rm_valid", rm_valid_o, 1'b1);
    check("single_rm_data", rm_data_o, 32'hA5A5_0001);
    cycle(0, 0, 0, 32'h0, 1, 0);
    cycle(0, 0, 0, 32'h0, 1, 0);
    check("single_busy_drop", busy_o, 1'b0);

    // Packet lock: select changes after beat 0 are ignored.
    cycle(1, 0, 0, 32'h10, 0, 1);
    cycle(1, 1, 0, 32'h11, 0, 1);
    cycle(1, 1, 0, 32'h12, 0, 1);
    cycle(1, 1, 1, 32'h13, 0, 1);
    check("lock_rm_valid", rm_valid_o, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 0, 1);

    // Backpressure on rm, then drain.
    for (int i = 0; i < 4; i++) cycle(1, 1, (i == 5), 32'h20 + i, 0, 0);
    check("bp_src_ready", src_ready_o, 1'b0);
    check("bp_rm_head", rm_data_o, 32'h20);
    for (int i = 4; i < 8; i++) cycle(1, 1, (i == 7), 32'h20 + i, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, 1, 0);

    // Back-to-back channel switch.
    cycle(1, 1, 0, 32'h1, 1, 1);
    cycle(1, 1, 1, 32'h2, 1, 1);
    cycle(1, 0, 1, 32'h3, 1, 1);
    cycle(0, 0, 0, 32'h0, 1, 1);
    cycle(0, 0, 0, 32'h0, 1, 1);

    // Async reset in the middle of a 5-beat dt packet.
    cycle(1, 0, 0, 32'h50, 0, 0);
    cycle(1, 0, 0, 32'h51, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    rmq.delete(); dtq.delete(); in_pkt = 0;
    src_valid_i = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1, 1, 1, 32'h60, 1, 1);
    check("post_rst_rm_valid", rm_valid_o, 1'b1);
    check("post_rst_dt_valid", dt_valid_o, 1'b0);
    cycle(0, 0, 0, 32'h0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(3, 0) != 0, $urandom_range(1, 0), $urandom_range(9, 0) < 3,
            $urandom, $urandom_range(4, 0) < 3, $urandom_range(4, 0) < 3);
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 32'h0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
